// File: rtl/regfile16_pkg.sv
// Shared constants for the register file: word length, register count,
// register address type and a one-hot helper used by the scoreboard.
package regfile16_pkg;

   localparam int WORD_LENGTH   = 16;
   localparam int REG_COUNT     = 16;
   localparam int REG_ADDR_BITS = 4;

   typedef logic [REG_ADDR_BITS-1:0] reg_addr_t;

   // One-hot decode of a register address, all zeros when the strobe is low.
   function automatic logic [REG_COUNT-1:0] addr_onehot(input reg_addr_t addr, input logic en);
      logic [REG_COUNT-1:0] mask;
      mask = '0;
      if (en) begin
         mask[addr] = 1'b1;
      end
      return mask;
   endfunction

endpackage

// File: rtl/regfile16_if.sv
// Register file bus: writeback, issue allocation and the two read ports.
// The master drives strobes/addresses/selects; the slave (regfile16)
// returns read data and pending status.
interface regfile16_if
   import regfile16_pkg::*;
#(
   parameter int n = WORD_LENGTH
);
   logic                 wr_en;
   reg_addr_t            wr_addr;
   logic [n-1:0]         wr_data;
   logic                 alloc_en;
   reg_addr_t            alloc_addr;
   reg_addr_t            rd_sel_a;
   logic [n-1:0]         rd_data_a;
   logic                 busy_a;
   reg_addr_t            rd_sel_b;
   logic [n-1:0]         rd_data_b;
   logic                 busy_b;
   logic [REG_COUNT-1:0] busy_vec;

   modport master (
      output wr_en, wr_addr, wr_data, alloc_en, alloc_addr, rd_sel_a, rd_sel_b,
      input  rd_data_a, busy_a, rd_data_b, busy_b, busy_vec
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, alloc_en, alloc_addr, rd_sel_a, rd_sel_b,
      output rd_data_a, busy_a, rd_data_b, busy_b, busy_vec
   );
endinterface

// File: rtl/regfile16_mux16.sv
// 16:1 read multiplexer of n-bit words, purely combinational.
module regfile16_mux16
   import regfile16_pkg::*;
#(
   parameter int n = WORD_LENGTH
) (
   input  logic [n-1:0] in00, in01, in02, in03, in04, in05, in06, in07,
   input  logic [n-1:0] in08, in09, in10, in11, in12, in13, in14, in15,
   input  reg_addr_t    sel,
   output logic [n-1:0] dout
);
   // Select one of the sixteen inputs.
   always_comb begin
      dout = '0;
      case (sel)
         4'd0:  dout = in00;
         4'd1:  dout = in01;
         4'd2:  dout = in02;
         4'd3:  dout = in03;
         4'd4:  dout = in04;
         4'd5:  dout = in05;
         4'd6:  dout = in06;
         4'd7:  dout = in07;
         4'd8:  dout = in08;
         4'd9:  dout = in09;
         4'd10: dout = in10;
         4'd11: dout = in11;
         4'd12: dout = in12;
         4'd13: dout = in13;
         4'd14: dout = in14;
         default: dout = in15;
      endcase
   end
endmodule

// File: rtl/regfile16_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by issue allocation,
// cleared by writeback. An allocation wins over a same-cycle writeback to the
// same register because the allocation is the younger operation. Bit 0 (R0)
// never becomes pending.
module regfile16_scoreboard
   import regfile16_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 alloc_en,
   input  reg_addr_t            alloc_addr,
   input  logic                 wr_en,
   input  reg_addr_t            wr_addr,
   output logic [REG_COUNT-1:0] busy_vec
);
   logic [REG_COUNT-1:0] pend_reg;
   logic [REG_COUNT-1:0] pend_next;

   // Next pending state: clear on writeback, then set on allocation.
   always_comb begin
      pend_next    = (pend_reg & ~addr_onehot(wr_addr, wr_en)) | addr_onehot(alloc_addr, alloc_en);
      pend_next[0] = 1'b0;
   end

   // Pending register, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_reg <= '0;
      end else begin
         pend_reg <= pend_next;
      end
   end

   assign busy_vec = pend_reg;
endmodule

// File: rtl/regfile16.sv
// 16 x n general-purpose register file with pending-write scoreboard.
// R0 reads as zero and ignores writes and allocations. Two 16:1 muxes form
// read ports A and B with zero-cycle latency.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle writeback
// to a read port that selects the written register.
module regfile16
   import regfile16_pkg::*;
#(
   parameter int n = WORD_LENGTH
) (
   input  logic        clk,
   input  logic        rst_n,
   regfile16_if.slave  bus
);
   logic [n-1:0] regs [REG_COUNT];
   logic [n-1:0] mux_a_out;
   logic [n-1:0] mux_b_out;

   // Architectural registers; R0 is held at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else begin
         regs[0] <= '0;
         for (int i = 1; i < REG_COUNT; i++) begin
            if (bus.wr_en && (bus.wr_addr == reg_addr_t'(i))) begin
               regs[i] <= bus.wr_data;
            end
         end
      end
   end

   regfile16_scoreboard u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .alloc_en   (bus.alloc_en),
      .alloc_addr (bus.alloc_addr),
      .wr_en      (bus.wr_en),
      .wr_addr    (bus.wr_addr),
      .busy_vec   (bus.busy_vec)
   );

   regfile16_mux16 #(.n(n)) MUX_A (
      .in00(regs[0]),  .in01(regs[1]),  .in02(regs[2]),  .in03(regs[3]),
      .in04(regs[4]),  .in05(regs[5]),  .in06(regs[6]),  .in07(regs[7]),
      .in08(regs[8]),  .in09(regs[9]),  .in10(regs[10]), .in11(regs[11]),
      .in12(regs[12]), .in13(regs[13]), .in14(regs[14]), .in15(regs[15]),
      .sel (bus.rd_sel_a),
      .dout(mux_a_out)
   );

   regfile16_mux16 #(.n(n)) MUX_B (
      .in00(regs[0]),  .in01(regs[1]),  .in02(regs[2]),  .in03(regs[3]),
      .in04(regs[4]),  .in05(regs[5]),  .in06(regs[6]),  .in07(regs[7]),
      .in08(regs[8]),  .in09(regs[9]),  .in10(regs[10]), .in11(regs[11]),
      .in12(regs[12]), .in13(regs[13]), .in14(regs[14]), .in15(regs[15]),
      .sel (bus.rd_sel_b),
      .dout(mux_b_out)
   );

`ifdef REGFILE_BYPASS_EN
   logic fwd_a;
   logic fwd_b;

   // Forward a writeback to a port selecting the same non-zero register.
   // Suppressed during reset, where the write would be discarded anyway.
   always_comb begin
      fwd_a = rst_n && bus.wr_en && (bus.wr_addr == bus.rd_sel_a) && (bus.wr_addr != '0);
      fwd_b = rst_n && bus.wr_en && (bus.wr_addr == bus.rd_sel_b) && (bus.wr_addr != '0);
      bus.rd_data_a = fwd_a ? bus.wr_data : mux_a_out;
      bus.rd_data_b = fwd_b ? bus.wr_data : mux_b_out;
      bus.busy_a    = fwd_a ? (bus.alloc_en && (bus.alloc_addr == bus.rd_sel_a))
                            : bus.busy_vec[bus.rd_sel_a];
      bus.busy_b    = fwd_b ? (bus.alloc_en && (bus.alloc_addr == bus.rd_sel_b))
                            : bus.busy_vec[bus.rd_sel_b];
   end
`else
   // Read ports reflect registered state only.
   always_comb begin
      bus.rd_data_a = mux_a_out;
      bus.rd_data_b = mux_b_out;
      bus.busy_a    = bus.busy_vec[bus.rd_sel_a];
      bus.busy_b    = bus.busy_vec[bus.rd_sel_b];
   end
`endif

endmodule

// File: tb/tb_regfile16.sv
// Testbench for regfile16: table-driven vectors plus hand-written sequences
// for forwarding and mid-operation reset. Expected outputs are queued when
// stimulus is driven and popped when the outputs are sampled.
module tb_regfile16;
   import regfile16_pkg::*;

   typedef struct {
      logic        we;
      logic [3:0]  wa;
      logic [15:0] wd;
      logic        ae;
      logic [3:0]  aa;
      logic [3:0]  sa;
      logic [3:0]  sb;
      logic [15:0] ea;
      logic [15:0] eb;
      logic        eba;
      logic        ebb;
      logic [15:0] ebv;
   } vec_t;

   typedef struct {
      string       name;
      logic [15:0] a;
      logic [15:0] b;
      logic        ba;
      logic        bb;
      logic [15:0] bv;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests_run = 0;
   int   tests_failed = 0;
   exp_t sb_q[$];
   vec_t tv[12];

   regfile16_if #(.n(WORD_LENGTH)) rf_if ();

   regfile16 #(.n(WORD_LENGTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (rf_if)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input string fld, input logic [15:0] got, input logic [15:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("FAIL %s %s: got %h want %h", nm, fld, got, want);
      end
   endtask

   task automatic push_exp(input string nm, input logic [15:0] a, input logic [15:0] b,
                           input logic ba, input logic bb, input logic [15:0] bv);
      exp_t e;
      e.name = nm; e.a = a; e.b = b; e.ba = ba; e.bb = bb; e.bv = bv;
      sb_q.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      if (sb_q.size() == 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL scoreboard: got empty queue want entry");
      end else begin
         e = sb_q.pop_front();
         $display("[TB] %s sel=%0d/%0d a=%h b=%h busy=%b%b vec=%h", e.name,
                  rf_if.rd_sel_a, rf_if.rd_sel_b, rf_if.rd_data_a, rf_if.rd_data_b,
                  rf_if.busy_a, rf_if.busy_b, rf_if.busy_vec);
         cmp(e.name, "rd_data_a", rf_if.rd_data_a, e.a);
         cmp(e.name, "rd_data_b", rf_if.rd_data_b, e.b);
         cmp(e.name, "busy_a", {15'd0, rf_if.busy_a}, {15'd0, e.ba});
         cmp(e.name, "busy_b", {15'd0, rf_if.busy_b}, {15'd0, e.bb});
         cmp(e.name, "busy_vec", rf_if.busy_vec, e.bv);
      end
   endtask

   task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                        input logic ae, input logic [3:0] aa, input logic [3:0] sa, input logic [3:0] sb);
      rf_if.wr_en = we; rf_if.wr_addr = wa; rf_if.wr_data = wd;
      rf_if.alloc_en = ae; rf_if.alloc_addr = aa;
      rf_if.rd_sel_a = sa; rf_if.rd_sel_b = sb;
   endtask

   task automatic idle_strobes();
      rf_if.wr_en = 1'b0;
      rf_if.alloc_en = 1'b0;
   endtask

   initial begin
      //          we wa   wd       ae aa  sa  sb   exp_a    exp_b    ba bb bv
      tv[0]  = '{1, 5,  16'hBEEF, 0, 0,  5,  5,  16'hBEEF, 16'hBEEF, 0, 0, 16'h0000};
      tv[1]  = '{1, 0,  16'h1234, 0, 0,  0,  5,  16'h0000, 16'hBEEF, 0, 0, 16'h0000};
      tv[2]  = '{0, 0,  16'h0000, 1, 7,  7,  5,  16'h0000, 16'hBEEF, 1, 0, 16'h0080};
      tv[3]  = '{0, 0,  16'h0000, 0, 0,  7,  7,  16'h0000, 16'h0000, 1, 1, 16'h0080};
      tv[4]  = '{0, 0,  16'h0000, 0, 0,  5,  7,  16'hBEEF, 16'h0000, 0, 1, 16'h0080};
      tv[5]  = '{1, 7,  16'h7777, 0, 0,  7,  5,  16'h7777, 16'hBEEF, 0, 0, 16'h0000};
      tv[6]  = '{1, 3,  16'h3333, 1, 3,  3,  7,  16'h3333, 16'h7777, 1, 0, 16'h0008};
      tv[7]  = '{0, 0,  16'h0000, 1, 0,  0,  3,  16'h0000, 16'h3333, 0, 1, 16'h0008};
      tv[8]  = '{1, 4,  16'h4444, 0, 0,  4,  3,  16'h4444, 16'h3333, 0, 1, 16'h0008};
      tv[9]  = '{0, 0,  16'h0000, 1, 3,  3,  4,  16'h3333, 16'h4444, 1, 0, 16'h0008};
      tv[10] = '{1, 3,  16'h0000, 1, 12, 3,  12, 16'h0000, 16'h0000, 0, 1, 16'h1000};
      tv[11] = '{1, 12, 16'hCCCC, 0, 0,  12, 0,  16'hCCCC, 16'h0000, 0, 0, 16'h0000};

      // Reset held with random stimulus: outputs must stay zero.
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 4; c++) begin
         drive(1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom), 4'($urandom),
               4'($urandom), 4'($urandom));
         push_exp($sformatf("reset_hold%0d", c), 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
         @(negedge clk);
         #1 check_out();
         @(posedge clk);
         #1;
      end

      // Release reset and read every register through both ports.
      @(negedge clk);
      idle_strobes();
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         rf_if.rd_sel_a = 4'(i);
         rf_if.rd_sel_b = 4'(15 - i);
         push_exp($sformatf("post_reset_r%0d", i), 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
         #1 check_out();
      end

      // Table vectors: apply strobes for one edge, then check registered state.
      for (int v = 0; v < 12; v++) begin
         @(posedge clk);
         #1 drive(tv[v].we, tv[v].wa, tv[v].wd, tv[v].ae, tv[v].aa, tv[v].sa, tv[v].sb);
         @(posedge clk);
         #1 idle_strobes();
         push_exp($sformatf("vec%0d", v), tv[v].ea, tv[v].eb, tv[v].eba, tv[v].ebb, tv[v].ebv);
         @(negedge clk);
         check_out();
      end

      // Same-cycle write to R9 while both ports select it.
      @(posedge clk);
      #1 drive(1, 9, 16'hA5A5, 0, 0, 9, 9);
`ifdef REGFILE_BYPASS_EN
      push_exp("fwd_same_cycle", 16'hA5A5, 16'hA5A5, 1'b0, 1'b0, 16'h0000);
`else
      push_exp("fwd_same_cycle", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
`endif
      @(negedge clk);
      check_out();
      @(posedge clk);
      #1 idle_strobes();
      push_exp("fwd_next_cycle", 16'hA5A5, 16'hA5A5, 1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      check_out();

      // Forwarded write plus allocation of the same register.
      @(posedge clk);
      #1 drive(1, 9, 16'h5A5A, 1, 9, 9, 5);
`ifdef REGFILE_BYPASS_EN
      push_exp("fwd_alloc_same", 16'h5A5A, 16'hBEEF, 1'b1, 1'b0, 16'h0000);
`else
      push_exp("fwd_alloc_same", 16'hA5A5, 16'hBEEF, 1'b0, 1'b0, 16'h0000);
`endif
      @(negedge clk);
      check_out();
      @(posedge clk);
      #1 idle_strobes();
      push_exp("fwd_alloc_next", 16'h5A5A, 16'hBEEF, 1'b1, 1'b0, 16'h0200);
      @(negedge clk);
      check_out();

      // R2 = 00FF and pending, then reset between clock edges.
      @(posedge clk);
      #1 drive(1, 2, 16'h00FF, 1, 2, 2, 9);
      @(posedge clk);
      #1 idle_strobes();
      push_exp("pre_async_reset", 16'h00FF, 16'h5A5A, 1'b1, 1'b1, 16'h0204);
      @(negedge clk);
      check_out();
      #2 rst_n = 1'b0;
      push_exp("async_reset_now", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
      #1 check_out();

      // Write and alloc presented while reset is held are lost.
      drive(1, 6, 16'h6666, 1, 6, 6, 9);
      push_exp("reset_inflight", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      check_out();

      // First edge after release updates state normally.
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 idle_strobes();
      push_exp("first_edge_after", 16'h6666, 16'h0000, 1'b1, 1'b0, 16'h0040);
      @(negedge clk);
      check_out();

      if (sb_q.size() != 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
